// File: rtl/decode_hazard_pkg.sv
// Shared types for the decode-stage hazard/forwarding unit: bypass select encoding and the
// per-stage shadow record kept for in-flight instructions.
package decode_hazard_pkg;

   // Widest register index the shadow records can hold; narrower indices are zero-extended.
   localparam int unsigned RegAddrMax = 8;

   typedef enum logic [1:0] {
      BYP_RF  = 2'b00,
      BYP_EX  = 2'b01,
      BYP_MEM = 2'b10,
      BYP_WB  = 2'b11
   } bypass_sel_t;

   typedef struct packed {
      logic                  valid;
      logic [RegAddrMax-1:0] rd;
      logic                  regwrite;
      logic                  is_load;
   } stage_info_t;

   // A stage can supply a source only if it really writes that non-zero register.
   function automatic logic stage_writes(input stage_info_t stage,
                                         input logic [RegAddrMax-1:0] src);
      return stage.valid && stage.regwrite && (stage.rd == src) && (src != '0);
   endfunction

endpackage

// File: rtl/decode_hazard_src_match.sv
// Compares one decode source against the E/M/W shadow stages and returns the youngest
// matching stage as a bypass select, plus load-in-E and any-stage hit flags.
module decode_hazard_src_match
   import decode_hazard_pkg::*;
(
   input  logic                  dec_valid,
   input  logic [RegAddrMax-1:0] src_addr,
   input  logic                  src_used,
   input  stage_info_t           stage_e,
   input  stage_info_t           stage_m,
   input  stage_info_t           stage_w,
   output bypass_sel_t           sel,
   output logic                  load_hit,
   output logic                  any_hit
);

   logic qual;
   logic hit_e;
   logic hit_m;
   logic hit_w;

   always_comb begin
      qual  = dec_valid && src_used;
      hit_e = qual && stage_writes(stage_e, src_addr);
      hit_m = qual && stage_writes(stage_m, src_addr);
      hit_w = qual && stage_writes(stage_w, src_addr);

      // Youngest producer holds the architecturally newest value.
      sel = BYP_RF;
      if (hit_e) begin
         sel = BYP_EX;
      end else if (hit_m) begin
         sel = BYP_MEM;
      end else if (hit_w) begin
         sel = BYP_WB;
      end

      load_hit = hit_e && stage_e.is_load;
      any_hit  = hit_e || hit_m || hit_w;
   end

endmodule

// File: rtl/decode_hazard_forward_unit.sv
// Decode-stage bypass select and stall generation with an E/M/W shadow pipeline.
// Define DECODE_BYPASS_EN for forwarding with 1-cycle load-use stall; otherwise stall until W drains.
module decode_hazard_forward_unit
   import decode_hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      dec_valid,
   input  logic [REG_ADDR_WIDTH-1:0] dec_rs1_addr,
   input  logic                      dec_rs1_used,
   input  logic [REG_ADDR_WIDTH-1:0] dec_rs2_addr,
   input  logic                      dec_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0] dec_rd_addr,
   input  logic                      dec_regwrite,
   input  logic                      dec_mem_read,
   input  logic                      flush,
   output logic [1:0]                rs1_data_bypass,
   output logic [1:0]                rs2_data_bypass,
   output logic                      stall
);

   stage_info_t stage_e_q, stage_e_d;
   stage_info_t stage_m_q, stage_m_d;
   stage_info_t stage_w_q, stage_w_d;

   logic [RegAddrMax-1:0] rs1_ext;
   logic [RegAddrMax-1:0] rs2_ext;
   logic [RegAddrMax-1:0] rd_ext;

   bypass_sel_t rs1_sel;
   bypass_sel_t rs2_sel;
   logic        rs1_load_hit;
   logic        rs2_load_hit;
   logic        rs1_any_hit;
   logic        rs2_any_hit;

   always_comb begin
      rs1_ext                     = '0;
      rs2_ext                     = '0;
      rd_ext                      = '0;
      rs1_ext[REG_ADDR_WIDTH-1:0] = dec_rs1_addr;
      rs2_ext[REG_ADDR_WIDTH-1:0] = dec_rs2_addr;
      rd_ext[REG_ADDR_WIDTH-1:0]  = dec_rd_addr;
   end

   decode_hazard_src_match u_rs1_match (
      .dec_valid (dec_valid),
      .src_addr  (rs1_ext),
      .src_used  (dec_rs1_used),
      .stage_e   (stage_e_q),
      .stage_m   (stage_m_q),
      .stage_w   (stage_w_q),
      .sel       (rs1_sel),
      .load_hit  (rs1_load_hit),
      .any_hit   (rs1_any_hit)
   );

   decode_hazard_src_match u_rs2_match (
      .dec_valid (dec_valid),
      .src_addr  (rs2_ext),
      .src_used  (dec_rs2_used),
      .stage_e   (stage_e_q),
      .stage_m   (stage_m_q),
      .stage_w   (stage_w_q),
      .sel       (rs2_sel),
      .load_hit  (rs2_load_hit),
      .any_hit   (rs2_any_hit)
   );

`ifdef DECODE_BYPASS_EN
   logic unused_any_hit;
   assign unused_any_hit  = rs1_any_hit ^ rs2_any_hit;

   // Only a load still in E lacks its data; everything older is forwardable.
   assign stall           = rs1_load_hit || rs2_load_hit;
   assign rs1_data_bypass = rs1_sel;
   assign rs2_data_bypass = rs2_sel;
`else
   logic unused_match;
   assign unused_match    = ^{rs1_sel, rs2_sel, rs1_load_hit, rs2_load_hit};

   // Without forwarding, wait until the producer has left W and the regfile holds its result.
   assign stall           = rs1_any_hit || rs2_any_hit;
   assign rs1_data_bypass = BYP_RF;
   assign rs2_data_bypass = BYP_RF;
`endif

   always_comb begin
      stage_e_d = '0;
      if (dec_valid && !stall && !flush) begin
         stage_e_d.valid    = 1'b1;
         stage_e_d.rd       = rd_ext;
         stage_e_d.regwrite = dec_regwrite;
         stage_e_d.is_load  = dec_mem_read;
      end
      stage_m_d = stage_e_q;
      stage_w_d = stage_m_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stage_e_q <= '0;
         stage_m_q <= '0;
         stage_w_q <= '0;
      end else begin
         stage_e_q <= stage_e_d;
         stage_m_q <= stage_m_d;
         stage_w_q <= stage_w_d;
      end
   end

endmodule

// File: tb/tb_decode_hazard_forward_unit.sv
// Table-driven bench for decode_hazard_forward_unit; expectations cover both the
// DECODE_BYPASS_EN build and the default stall-only build.
module tb_decode_hazard_forward_unit;

`ifdef DECODE_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset;
   logic       dec_valid;
   logic [4:0] dec_rs1_addr;
   logic       dec_rs1_used;
   logic [4:0] dec_rs2_addr;
   logic       dec_rs2_used;
   logic [4:0] dec_rd_addr;
   logic       dec_regwrite;
   logic       dec_mem_read;
   logic       flush;
   logic [1:0] rs1_data_bypass;
   logic [1:0] rs2_data_bypass;
   logic       stall;

   always #5 clock = ~clock;

   decode_hazard_forward_unit #(
      .REG_ADDR_WIDTH (5)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .dec_valid       (dec_valid),
      .dec_rs1_addr    (dec_rs1_addr),
      .dec_rs1_used    (dec_rs1_used),
      .dec_rs2_addr    (dec_rs2_addr),
      .dec_rs2_used    (dec_rs2_used),
      .dec_rd_addr     (dec_rd_addr),
      .dec_regwrite    (dec_regwrite),
      .dec_mem_read    (dec_mem_read),
      .flush           (flush),
      .rs1_data_bypass (rs1_data_bypass),
      .rs2_data_bypass (rs2_data_bypass),
      .stall           (stall)
   );

   // One row = one decode cycle; rst rows are not checked.
   typedef struct {
      logic       rst;
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       ld;
      logic       fl;
      logic [1:0] e1;     // rs1 select with bypass enabled
      logic [1:0] e2;     // rs2 select with bypass enabled
      logic       st_byp; // stall with bypass enabled
      logic       st_nb;  // stall with bypass disabled
      string      name;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic row(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic ld, input logic fl,
                      input logic [1:0] e1, input logic [1:0] e2, input logic sb,
                      input logic sn, input string name);
      vec_t r;
      r.rst = 1'b0; r.v = v; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
      r.rd = rd; r.rw = rw; r.ld = ld; r.fl = fl;
      r.e1 = e1; r.e2 = e2; r.st_byp = sb; r.st_nb = sn; r.name = name;
      vecs.push_back(r);
   endtask

   task automatic rst_row();
      vec_t r;
      r = '{rst: 1'b1, v: 1'b0, rs1: 5'd0, u1: 1'b0, rs2: 5'd0, u2: 1'b0, rd: 5'd0,
            rw: 1'b0, ld: 1'b0, fl: 1'b0, e1: 2'b00, e2: 2'b00, st_byp: 1'b0,
            st_nb: 1'b0, name: "rst"};
      vecs.push_back(r);
   endtask

   task automatic wr(input logic [4:0] rd, input logic ld);
      row(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, ld, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "prod");
   endtask

   task automatic nop();
      row(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, "nop");
   endtask

   task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t r);
      reset        = r.rst;
      dec_valid    = r.v;
      dec_rs1_addr = r.rs1;
      dec_rs1_used = r.u1;
      dec_rs2_addr = r.rs2;
      dec_rs2_used = r.u2;
      dec_rd_addr  = r.rd;
      dec_regwrite = r.rw;
      dec_mem_read = r.ld;
      flush        = r.fl;
   endtask

   initial begin
      vec_t r;
      // Reset state
      rst_row();
      row(1, 5, 1, 6, 1, 7, 1, 0, 0, 2'b00, 2'b00, 0, 0, "reset_state");
      // Forward from E
      rst_row(); wr(5, 0);
      row(1, 5, 1, 0, 0, 10, 1, 0, 0, 2'b01, 2'b00, 0, 1, "e_fwd");
      // Youngest wins
      rst_row(); wr(5, 0); wr(5, 0);
      row(1, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b01, 0, 1, "youngest");
      // Both sources on one stage
      rst_row(); wr(6, 0);
      row(1, 6, 1, 6, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0, 1, "e_both");
      rst_row(); wr(6, 0); nop();
      row(1, 6, 1, 6, 1, 0, 0, 0, 0, 2'b10, 2'b10, 0, 1, "m_both");
      rst_row(); wr(6, 0); nop(); nop();
      row(1, 6, 1, 2, 1, 0, 0, 0, 0, 2'b11, 2'b00, 0, 1, "w_fwd");
      // Load-use
      rst_row(); wr(7, 1);
      row(1, 7, 1, 0, 0, 11, 1, 0, 0, 2'b01, 2'b00, 1, 1, "lu_stall");
      row(1, 7, 1, 0, 0, 11, 1, 0, 0, 2'b10, 2'b00, 0, 1, "lu_mem");
      row(1, 7, 1, 0, 0, 11, 1, 0, 0, 2'b11, 2'b00, 0, 1, "lu_wb");
      row(1, 7, 1, 0, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0, "lu_rf");
      // ALU dependency: 3-cycle stall without bypass
      rst_row(); wr(4, 0);
      row(1, 4, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 1, "alu_e");
      row(1, 4, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 1, "alu_m");
      row(1, 4, 1, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 1, "alu_w");
      row(1, 4, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "alu_rf");
      // x0 and unused sources
      rst_row(); wr(3, 0); wr(0, 0);
      row(1, 0, 1, 3, 0, 12, 0, 0, 0, 2'b00, 2'b00, 0, 0, "x0_unused");
      nop();
      row(1, 0, 1, 3, 0, 12, 0, 0, 0, 2'b00, 2'b00, 0, 0, "x0_in_w");
      rst_row(); wr(3, 0); nop(); nop();
      row(1, 0, 1, 3, 0, 12, 0, 0, 0, 2'b00, 2'b00, 0, 0, "unused_w");
      rst_row(); wr(5, 0);
      row(0, 5, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "invalid_dec");
      // Flush kills decode entry
      rst_row();
      row(1, 0, 0, 0, 0, 9, 1, 0, 1, 2'b00, 2'b00, 0, 0, "flush_row");
      row(1, 9, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "flush_kill");
      // Stall and flush together
      rst_row(); wr(7, 1);
      row(1, 7, 1, 0, 0, 11, 1, 0, 1, 2'b01, 2'b00, 1, 1, "stall_flush");
      row(1, 7, 1, 0, 0, 11, 1, 0, 0, 2'b10, 2'b00, 0, 1, "after_flush");
      // Reset in the middle of a stall
      rst_row(); wr(7, 1);
      row(1, 7, 1, 0, 0, 11, 1, 0, 0, 2'b01, 2'b00, 1, 1, "pre_rst");
      rst_row();
      row(1, 7, 1, 0, 0, 11, 1, 0, 0, 2'b00, 2'b00, 0, 0, "rst_mid_stall");

      foreach (vecs[i]) begin
         r = vecs[i];
         @(negedge clock);
         drive(r);
         #1;
         if (!r.rst) begin
            check({r.name, ".rs1"}, rs1_data_bypass, Byp ? r.e1 : 2'b00);
            check({r.name, ".rs2"}, rs2_data_bypass, Byp ? r.e2 : 2'b00);
            check({r.name, ".stall"}, {1'b0, stall}, {1'b0, Byp ? r.st_byp : r.st_nb});
         end
      end

      // Hand sequence: reset held two cycles over a hazard clears everything.
      @(negedge clock);
      reset = 1'b0; dec_valid = 1'b1; dec_rs1_addr = 5'd0; dec_rs1_used = 1'b0;
      dec_rs2_addr = 5'd0; dec_rs2_used = 1'b0; dec_rd_addr = 5'd8;
      dec_regwrite = 1'b1; dec_mem_read = 1'b1; flush = 1'b0;
      @(negedge clock);
      dec_rs1_addr = 5'd8; dec_rs1_used = 1'b1; dec_rs2_addr = 5'd8; dec_rs2_used = 1'b1;
      #1;
      check("hand_lu_stall", {1'b0, stall}, 2'b01);
      check("hand_lu_rs2", rs2_data_bypass, Byp ? 2'b01 : 2'b00);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("hand_rst_stall", {1'b0, stall}, 2'b00);
      check("hand_rst_rs1", rs1_data_bypass, 2'b00);
      check("hand_rst_rs2", rs2_data_bypass, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
